// File: rtl/fms_i2s_out_pkg.sv
// Shared I2S slot constants and helpers for the fmicrosynth audio output stage.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: LRCK polarity, slot-to-channel mapping, slot-to-frame-bit mapping.
package fms_i2s_out_pkg;

  // Word-select polarity: low while the left word is on the wire.
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  // Slots 0..data_bits-1 carry LRCK low, the upper half LRCK high.
  function automatic logic slot_is_right(input int slot, input int data_bits);
    return slot >= data_bits;
  endfunction

  // Index into the {left, right} frame register of the bit driven on entering
  // a slot. Slot 0 carries the right LSB of the previous frame (Philips
  // one-bit lag), slots 1..2*data_bits-1 walk MSB-first through L then R.
  function automatic int slot_bit_index(input int slot, input int data_bits);
    return (slot == 0) ? 0 : (2 * data_bits - slot);
  endfunction

endpackage

// File: rtl/fms_bclk_gen.sv
// BCLK generator: divides clk by 2*BCLK_DIV and flags the edge about to happen.
// Latency: i2s_bclk toggles on the clock edge where fall_tick/rise_tick is high.
// Backpressure: none; free-running from reset release.
// Ports: clk, reset (sync, active-high); i2s_bclk bit clock;
//        fall_tick / rise_tick: one-cycle strobes, high in the cycle whose
//        closing edge takes i2s_bclk 1->0 / 0->1.
module fms_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic i2s_bclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          tick;

  assign tick      = (div_q == DIV_LAST);
  assign fall_tick = tick & i2s_bclk;
  assign rise_tick = tick & ~i2s_bclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      i2s_bclk <= 1'b0;
    end else if (tick) begin
      div_q    <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_q    <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/fms_i2s_out.sv
// I2S (Philips) transmitter for the fmicrosynth core with the synth trigger handshake.
// Latency: pair latched at the frame boundary; left MSB on i2s_sdata one BCLK later.
// Backpressure: synth still running at a boundary -> previous pair repeated, underrun flagged.
// Ports: clk, reset (sync, active-high); sample_l/sample_r + running from the
//        synth; trigger one-cycle start pulse back to it; i2s_bclk/i2s_lrck/
//        i2s_sdata DAC pins; underrun sticky flag, cleared by underrun_clr.
module fms_i2s_out
  import fms_i2s_out_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int BCLK_DIV  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] sample_l,
  input  logic [DATA_BITS-1:0] sample_r,
  input  logic                 running,
  output logic                 trigger,
  input  logic                 underrun_clr,
  output logic                 i2s_bclk,
  output logic                 i2s_lrck,
  output logic                 i2s_sdata,
  output logic                 underrun
);

  localparam int FRAME_SLOTS = 2 * DATA_BITS;
  localparam int SW          = $clog2(FRAME_SLOTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_SLOTS - 1);

  logic                   fall_tick;
  logic                   rise_tick_unused;
  logic [SW-1:0]          slot_q;
  logic [SW-1:0]          slot_nxt;
  logic [SW-1:0]          bit_idx;
  logic [FRAME_SLOTS-1:0] frame_q;   // {left, right} currently being sent
  logic                   exempt_q;  // first boundary after reset never underruns
  logic                   boundary;

  fms_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .reset     (reset),
    .i2s_bclk  (i2s_bclk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick_unused)
  );

  always_comb begin
    slot_nxt = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
    bit_idx  = SW'(slot_bit_index(int'(slot_nxt), DATA_BITS));
  end

  assign boundary = fall_tick && (slot_q == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= LAST_SLOT;
      frame_q   <= '0;
      exempt_q  <= 1'b1;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      trigger   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      trigger <= 1'b0;

      if (fall_tick) begin
        slot_q    <= slot_nxt;
        i2s_lrck  <= slot_is_right(int'(slot_nxt), DATA_BITS) ? LRCK_RIGHT : LRCK_LEFT;
        // At the boundary bit_idx is 0, so this still reads the old pair's
        // right LSB before frame_q is reloaded below.
        i2s_sdata <= frame_q[bit_idx];
      end

      if (boundary) begin
        exempt_q <= 1'b0;
        if (!running) begin
          frame_q <= {sample_l, sample_r};
          trigger <= 1'b1;
        end
      end

      // A fresh underrun takes priority over a clear in the same cycle.
      if (boundary && running && !exempt_q) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fms_i2s_out.sv
module tb_fms_i2s_out;
  import fms_i2s_out_pkg::*;

  localparam int DB        = 16;
  localparam int DIV       = 2;
  localparam int FRAME     = 4 * DIV * DB;
  localparam int SLOT_CLKS = 2 * DIV;

  logic          clk = 1'b0;
  logic          reset;
  logic          running;
  logic          trigger;
  logic          underrun_clr;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_sdata;
  logic          underrun;
  logic [DB-1:0] sample_l;
  logic [DB-1:0] sample_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fms_i2s_out #(
    .DATA_BITS (DB),
    .BCLK_DIV  (DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .running      (running),
    .trigger      (trigger),
    .underrun_clr (underrun_clr),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model (closed-form frame timing) ----------------
  int             cyc;
  int             bnd_cnt = 0;
  bit             first, ur_model, trig_exp, bnd_now, clr_seen;
  logic [2*DB-1:0] ref_pair;
  logic [2*DB-1:0] exp_q[$];

  function automatic bit is_bnd(input int c);
    return (c >= 2 * DIV) && (((c - 2 * DIV) % FRAME) == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cyc      = 0;
      ref_pair = '0;
      first    = 1'b1;
      ur_model = 1'b0;
      trig_exp = 1'b0;
      bnd_now  = 1'b0;
      clr_seen = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      bnd_now  = is_bnd(cyc);
      trig_exp = bnd_now && !running;
      clr_seen = underrun_clr;
      if (bnd_now) begin
        if (!running) ref_pair = {sample_l, sample_r};
        exp_q.push_back(ref_pair);
        bnd_cnt++;
      end
      if (bnd_now && running && !first) ur_model = 1'b1;
      else if (underrun_clr)            ur_model = 1'b0;
      if (bnd_now) first = 1'b0;
    end
  end

  // ---------------- monitor: handshake checks + I2S receiver ----------------
  bit            prev_bclk, synced, lr_bad;
  int            bit_j, fcount;
  logic [DB-1:0] dl, dr;

  always @(negedge clk) begin
    if (reset) begin
      synced    = 1'b0;
      bit_j     = 0;
      fcount    = 0;
      lr_bad    = 1'b0;
    end else begin
      if (trig_exp || trigger) chk("trigger", 64'(trigger), 64'(trig_exp));
      if (bnd_now || clr_seen) chk("underrun", 64'(underrun), 64'(ur_model));

      if (prev_bclk && !i2s_bclk && !synced) begin
        synced = 1'b1;
        bit_j  = 0;
        chk("first_boundary_clock", 64'(cyc), 64'(2 * DIV));
      end else if (!prev_bclk && i2s_bclk && synced) begin
        if (bit_j == 0) begin
          if (fcount > 0) begin
            dr = {dr[DB-2:0], i2s_sdata};
            if (exp_q.size() == 0) begin
              chk("frame_queue_empty", 64'(1), 64'(0));
            end else begin
              chk("frame_data", 64'({dl, dr}), 64'(exp_q.pop_front()));
            end
            chk("lrck_pattern", 64'(lr_bad), 64'(0));
          end
          fcount++;
          lr_bad = 1'b0;
        end else if (bit_j <= DB) begin
          dl = {dl[DB-2:0], i2s_sdata};
        end else begin
          dr = {dr[DB-2:0], i2s_sdata};
        end
        if (i2s_lrck !== ((bit_j >= DB) ? LRCK_RIGHT : LRCK_LEFT)) lr_bad = 1'b1;
        bit_j = (bit_j + 1) % (2 * DB);
      end
    end
    prev_bclk = i2s_bclk;
  end

  // ---------------- stimulus ----------------
  task automatic wait_bnd();
    int start = bnd_cnt;
    for (int i = 0; i < 2 * FRAME + 4 * DIV; i++) begin
      @(negedge clk);
      if (bnd_cnt != start) return;
    end
    chk("boundary_timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_pre_bnd();
    for (int i = 0; i < 2 * FRAME + 4 * DIV; i++) begin
      @(negedge clk);
      if (is_bnd(cyc + 1)) return;
    end
    chk("pre_boundary_timeout", 64'(1), 64'(0));
  endtask

  // Synth stand-in: busy for a random time after each trigger, then offers a new pair.
  task automatic synth_frames(input int n);
    for (int i = 0; i < n; i++) begin
      running  = 1'b1;
      sample_l = DB'($urandom);
      sample_r = DB'($urandom);
      repeat ($urandom_range(1, FRAME - 8)) @(negedge clk);
      running = 1'b0;
      wait_bnd();
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_bclk"},     64'(i2s_bclk),  64'(0));
    chk({tag, "_lrck"},     64'(i2s_lrck),  64'(0));
    chk({tag, "_sdata"},    64'(i2s_sdata), 64'(0));
    chk({tag, "_trigger"},  64'(trigger),   64'(0));
    chk({tag, "_underrun"}, 64'(underrun),  64'(0));
  endtask

  initial begin
    reset        = 1'b1;
    running      = 1'b1;
    underrun_clr = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    // First boundary with synth busy: exempt, zeros transmitted.
    wait_bnd();
    sample_l = 16'hA5C3;
    sample_r = 16'h3C5A;
    running  = 1'b0;
    wait_bnd();
    chk("second_boundary_trigger", 64'(trigger), 64'(1));
    @(negedge clk);
    chk("trigger_one_cycle", 64'(trigger), 64'(0));
    synth_frames(40);

    // Underrun: synth stays busy across a boundary.
    running = 1'b1;
    wait_bnd();
    repeat (20) @(negedge clk);
    chk("underrun_sticky", 64'(underrun), 64'(1));
    // Clear coincides with another underrun boundary: set wins.
    wait_pre_bnd();
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_set_wins", 64'(underrun), 64'(1));
    repeat (5) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_cleared", 64'(underrun), 64'(0));

    // Race: running drops just after the boundary edge samples it.
    wait_pre_bnd();
    @(posedge clk);
    #1 running = 1'b0;
    @(negedge clk);
    chk("race_underrun", 64'(underrun), 64'(1));
    chk("race_no_trigger", 64'(trigger), 64'(0));
    sample_l = DB'($urandom);
    sample_r = DB'($urandom);
    wait_bnd();
    chk("race_next_trigger", 64'(trigger), 64'(1));
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    synth_frames(10);

    // Reset in the middle of slot 7.
    wait_pre_bnd();
    repeat (1 + 7 * SLOT_CLKS) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    reset   = 1'b0;
    running = 1'b0;
    wait_bnd();
    chk("post_reset_trigger", 64'(trigger), 64'(1));
    synth_frames(5);
    repeat (FRAME / 2) @(negedge clk);
    chk("frames_after_reset", 64'(fcount >= 6), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
